// File: rtl/axil_mem_slave.sv
// axil_mem_slave: AXI4-Lite slave in front of a DEPTH x DATA_W word RAM.
// The read and write engines are independent and run concurrently.
// AW and W may arrive in either order or in the same cycle.
// Byte strobes are honoured, and a read takes one cycle from AR handshake to rvalid.
// Responses: OKAY for aligned in-range accesses, SLVERR for misaligned ones,
// DECERR for out-of-range ones. Misalignment wins over range, and an error
// access never touches the RAM.
// Optional macro AXIL_MEM_ERR_CNT_EN adds a saturating 16-bit err_cnt output.
// That counter counts B and R handshakes whose response is not OKAY.
//
// state  | meaning
// W_IDLE | collecting AW and W into holding regs; commit when both present
// W_RESP | write response pending, waiting for bready
// R_IDLE | arready high, waiting for an address
// R_DATA | read data pending, waiting for rready
module axil_mem_slave #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 128
) (
    input  logic                s_axi_aclk,
    input  logic                s_axi_aresetn,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [ADDR_W-1:0]   s_axi_awaddr,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    input  logic [DATA_W-1:0]   s_axi_wdata,
    input  logic [DATA_W/8-1:0] s_axi_wstrb,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    output logic [1:0]          s_axi_bresp,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    input  logic [ADDR_W-1:0]   s_axi_araddr,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready,
    output logic [DATA_W-1:0]   s_axi_rdata,
    output logic [1:0]          s_axi_rresp
`ifdef AXIL_MEM_ERR_CNT_EN
    ,
    output logic [15:0]         err_cnt
`endif
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic { W_IDLE, W_RESP } w_state_t;
    typedef enum logic { R_IDLE, R_DATA } r_state_t;

    function automatic logic [1:0] f_decode(input logic [ADDR_W-1:0] addr);
        if (addr[LSB-1:0] != '0)
            return RESP_SLVERR;
        else if (addr[ADDR_W-1:LSB+IDX_W] != '0)
            return RESP_DECERR;
        else
            return RESP_OKAY;
    endfunction

    logic [DATA_W-1:0] r_mem [DEPTH];

    // ---------------- write engine ----------------
    w_state_t           r_wstate;
    logic               r_aw_held;
    logic               r_w_held;
    logic [ADDR_W-1:0]  r_awaddr;
    logic [DATA_W-1:0]  r_wdata;
    logic [STRB_W-1:0]  r_wstrb;
    logic               r_awready;
    logic               r_wready;
    logic               r_bvalid;
    logic [1:0]         r_bresp;

    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;
    logic               w_commit;
    logic [ADDR_W-1:0]  w_wr_addr;
    logic [DATA_W-1:0]  w_wr_data;
    logic [STRB_W-1:0]  w_wr_strb;
    logic [1:0]         w_wr_resp;
    logic [IDX_W-1:0]   w_wr_idx;

    // A channel captured on this very edge is used straight from the bus.
    assign w_aw_hs   = s_axi_awvalid & r_awready;
    assign w_w_hs    = s_axi_wvalid & r_wready;
    assign w_b_hs    = r_bvalid & s_axi_bready;
    assign w_wr_addr = r_aw_held ? r_awaddr : s_axi_awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s_axi_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_axi_wstrb;
    assign w_wr_resp = f_decode(w_wr_addr);
    assign w_wr_idx  = w_wr_addr[LSB+IDX_W-1:LSB];
    assign w_commit  = (r_wstate == W_IDLE) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    // Write FSM: gather AW/W independently, commit, then hold B until accepted.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_resp;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_wstate  <= W_RESP;
                    end else begin
                        if (w_aw_hs) begin
                            r_aw_held <= 1'b1;
                            r_awaddr  <= s_axi_awaddr;
                        end
                        if (w_w_hs) begin
                            r_w_held <= 1'b1;
                            r_wdata  <= s_axi_wdata;
                            r_wstrb  <= s_axi_wstrb;
                        end
                        r_awready <= ~(r_aw_held | w_aw_hs);
                        r_wready  <= ~(r_w_held | w_w_hs);
                    end
                end
                W_RESP: begin
                    if (w_b_hs) begin
                        r_bvalid  <= 1'b0;
                        r_bresp   <= RESP_OKAY;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // RAM byte-lane update on an OKAY commit; contents deliberately not reset.
    always_ff @(posedge s_axi_aclk) begin
        if (w_commit && (w_wr_resp == RESP_OKAY)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_wr_strb[i])
                    r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    r_state_t           r_rstate;
    logic               r_arready;
    logic               r_rvalid;
    logic [DATA_W-1:0]  r_rdata;
    logic [1:0]         r_rresp;

    logic               w_ar_hs;
    logic               w_r_hs;
    logic [1:0]         w_rd_resp;
    logic [IDX_W-1:0]   w_rd_idx;

    assign w_ar_hs   = s_axi_arvalid & r_arready;
    assign w_r_hs    = r_rvalid & s_axi_rready;
    assign w_rd_resp = f_decode(s_axi_araddr);
    assign w_rd_idx  = s_axi_araddr[LSB+IDX_W-1:LSB];

    // Read FSM: RAM sampled on the AR edge (pre-write value on a collision).
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rresp   <= w_rd_resp;
                        r_rdata   <= (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (w_r_hs) begin
                        r_rvalid  <= 1'b0;
                        r_rdata   <= '0;
                        r_rresp   <= RESP_OKAY;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

`ifdef AXIL_MEM_ERR_CNT_EN
    logic [15:0] r_err_cnt;
    logic [1:0]  w_err_inc;
    logic [16:0] w_err_sum;

    assign w_err_inc = {1'b0, w_b_hs & (r_bresp != RESP_OKAY)}
                     + {1'b0, w_r_hs & (r_rresp != RESP_OKAY)};
    assign w_err_sum = {1'b0, r_err_cnt} + {15'b0, w_err_inc};

    // Saturating count of error responses accepted by the master.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn)
            r_err_cnt <= '0;
        else
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end

    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_axil_mem_slave.sv
// tb_axil_mem_slave: directed scenarios plus a randomized sequence.
// The randomized sequence is checked against a word-array model of the RAM
// and address-rule response model.
module tb_axil_mem_slave;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
`ifdef AXIL_MEM_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    axil_mem_slave #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awaddr(awaddr),
        .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
        .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_bresp(bresp),
        .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_araddr(araddr),
        .s_axi_rvalid(rvalid), .s_axi_rready(rready), .s_axi_rdata(rdata), .s_axi_rresp(rresp)
`ifdef AXIL_MEM_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Response the address rules predict, from plain arithmetic on the byte address.
    function automatic logic [1:0] exp_resp(input logic [31:0] a);
        if (a % 4 != 0) return 2'b10;
        if (a >= DEPTH * 4) return 2'b11;
        return 2'b00;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (exp_resp(a) != 2'b00) return;
        idx = int'(a / 4);
        for (int i = 0; i < 4; i++)
            if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_aw(input logic [31:0] a, input int dly);
        int n = 0;
        repeat (dly) tick();
        awvalid = 1'b1;
        awaddr  = a;
        while (!awready && n < 50) begin tick(); n++; end
        if (!awready) begin
            checks++; errors++;
            $display("FAIL aw_timeout: awready=%0b required 1", awready);
            awvalid = 1'b0;
            return;
        end
        tick();
        awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        int n = 0;
        repeat (dly) tick();
        wvalid = 1'b1;
        wdata  = d;
        wstrb  = s;
        while (!wready && n < 50) begin tick(); n++; end
        if (!wready) begin
            checks++; errors++;
            $display("FAIL w_timeout: wready=%0b required 1", wready);
            wvalid = 1'b0;
            return;
        end
        tick();
        wvalid = 1'b0;
    endtask

    // Full write transaction; lat = cycles from last of AW/W handshake to bvalid visible, minus one.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly,
                            output logic [1:0] resp, output int lat);
        fork
            drive_aw(a, aw_dly);
            drive_w(d, s, w_dly);
        join
        lat = 0;
        while (!bvalid && lat < 50) begin tick(); lat++; end
        if (!bvalid) begin
            checks++; errors++;
            $display("FAIL b_timeout: bvalid=%0b required 1", bvalid);
            resp = 2'bxx;
            return;
        end
        resp = bresp;
        model_write(a, d, s);
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                           output logic [1:0] resp, output int lat);
        int n = 0;
        arvalid = 1'b1;
        araddr  = a;
        while (!arready && n < 50) begin tick(); n++; end
        if (!arready) begin
            checks++; errors++;
            $display("FAIL ar_timeout: arready=%0b required 1", arready);
            arvalid = 1'b0;
            d = 'x; resp = 'x; lat = 99;
            return;
        end
        tick();
        arvalid = 1'b0;
        lat = 0;
        while (!rvalid && lat < 50) begin tick(); lat++; end
        if (!rvalid) begin
            checks++; errors++;
            $display("FAIL r_timeout: rvalid=%0b required 1", rvalid);
            d = 'x; resp = 'x;
            return;
        end
        d    = rdata;
        resp = rresp;
        tick();
    endtask

    task automatic test_reset();
        logic [40:0] outs;
        rst_n = 1'b0;
        repeat (3) tick();
        outs = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp};
        checks++;
        if (outs !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
`ifdef AXIL_MEM_ERR_CNT_EN
        checks++;
        if (err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %0d required 0", err_cnt);
        end
`endif
        rst_n = 1'b1;
        tick();
        checks++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            errors++;
            $display("FAIL post_reset_ready: got %b required 11100",
                     {awready, wready, arready, bvalid, rvalid});
        end
    endtask

    task automatic test_prefill();
        logic [1:0] r;
        int lat;
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            do_write(32'(i * 4), $urandom, 4'hF, 0, 0, r, lat);
            if (r !== 2'b00 || lat != 0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL prefill: %0d bad writes required 0", bad);
        end
    endtask

    task automatic test_aligned_rw();
        logic [1:0] r;
        logic [31:0] d;
        int lat;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0, r, lat);
        checks++;
        if (r !== 2'b00 || lat != 0) begin
            errors++;
            $display("FAIL aligned_write: bresp=%b lat=%0d required 00 lat 0", r, lat);
        end
        do_read(32'h10, d, r, lat);
        checks++;
        if (d !== 32'hDEADBEEF || r !== 2'b00 || lat != 0) begin
            errors++;
            $display("FAIL aligned_read: data=%h rresp=%b lat=%0d required deadbeef 00 lat 0", d, r, lat);
        end
    endtask

    task automatic test_channel_order();
        logic [1:0] r;
        logic [31:0] d, d2;
        int lat;
        logic early_b = 1'b0;
        wvalid = 1'b1; wdata = 32'h11223344; wstrb = 4'hF;
        tick();
        wdata = 32'hBAD0BAD0;
        checks++;
        if ({wready, awready, bvalid} !== 3'b010) begin
            errors++;
            $display("FAIL w_first_hold: wready/awready/bvalid=%b required 010", {wready, awready, bvalid});
        end
        tick();
        if (bvalid) early_b = 1'b1;
        tick();
        if (bvalid) early_b = 1'b1;
        checks++;
        if (early_b !== 1'b0) begin
            errors++;
            $display("FAIL w_first_early_b: bvalid seen=%b required 0", early_b);
        end
        awvalid = 1'b1; awaddr = 32'h20;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL w_first_commit: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        model[8] = 32'h11223344;
        tick();
        d2 = $urandom;
        do_write(32'h24, d2, 4'hF, 0, 2, r, lat);
        checks++;
        if (r !== 2'b00 || lat != 0) begin
            errors++;
            $display("FAIL aw_first_write: bresp=%b lat=%0d required 00 lat 0", r, lat);
        end
        do_read(32'h20, d, r, lat);
        checks++;
        if (d !== 32'h11223344 || r !== 2'b00) begin
            errors++;
            $display("FAIL w_first_readback: data=%h rresp=%b required 11223344 00", d, r);
        end
        do_read(32'h24, d, r, lat);
        checks++;
        if (d !== d2 || r !== 2'b00) begin
            errors++;
            $display("FAIL aw_first_readback: data=%h rresp=%b required %h 00", d, r, d2);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r;
        logic [31:0] d;
        int lat;
        do_write(32'h30, 32'hAABBCCDD, 4'hF, 0, 0, r, lat);
        do_write(32'h30, 32'h00000055, 4'b0001, 1, 0, r, lat);
        do_read(32'h30, d, r, lat);
        checks++;
        if (d !== 32'hAABBCC55 || r !== 2'b00) begin
            errors++;
            $display("FAIL strobe_readback: data=%h rresp=%b required aabbcc55 00", d, r);
        end
    endtask

    task automatic test_errors();
        logic [1:0] r;
        logic [31:0] d, w0, w4, w127;
        int lat;
`ifdef AXIL_MEM_ERR_CNT_EN
        logic [15:0] e0 = err_cnt;
`endif
        w0 = model[0]; w4 = model[4]; w127 = model[127];
        do_write(32'h200, 32'hCAFEF00D, 4'hF, 0, 0, r, lat);
        checks++;
        if (r !== 2'b11) begin
            errors++;
            $display("FAIL err_range_write: bresp=%b required 11", r);
        end
        do_write(32'h13, 32'hCAFEF00D, 4'hF, 0, 1, r, lat);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("FAIL err_align_write: bresp=%b required 10", r);
        end
        do_read(32'h1FC, d, r, lat);
        checks++;
        if (r !== 2'b00 || d !== w127) begin
            errors++;
            $display("FAIL last_word_read: data=%h rresp=%b required %h 00", d, r, w127);
        end
`ifdef AXIL_MEM_ERR_CNT_EN
        checks++;
        if (err_cnt !== e0 + 16'd2) begin
            errors++;
            $display("FAIL err_cnt_two: got %0d required %0d", err_cnt, e0 + 16'd2);
        end
`endif
        do_read(32'h0, d, r, lat);
        checks++;
        if (d !== w0) begin
            errors++;
            $display("FAIL err_no_change_w0: data=%h required %h", d, w0);
        end
        do_read(32'h10, d, r, lat);
        checks++;
        if (d !== w4) begin
            errors++;
            $display("FAIL err_no_change_w4: data=%h required %h", d, w4);
        end
        do_read(32'h202, d, r, lat);
        checks++;
        if (r !== 2'b10 || d !== 32'd0) begin
            errors++;
            $display("FAIL err_read_priority: data=%h rresp=%b required 0 10", d, r);
        end
`ifdef AXIL_MEM_ERR_CNT_EN
        checks++;
        if (err_cnt !== e0 + 16'd3) begin
            errors++;
            $display("FAIL err_cnt_three: got %0d required %0d", err_cnt, e0 + 16'd3);
        end
`endif
    endtask

    task automatic test_backpressure_collision();
        logic [31:0] oldv, newv, d;
        logic [1:0] r;
        int lat;
        logic unstable = 1'b0;
        oldv = model[16];
        newv = ~oldv;
        bready  = 1'b0;
        awvalid = 1'b1; awaddr = 32'h40;
        wvalid  = 1'b1; wdata = newv; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 32'h40;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== oldv || rresp !== 2'b00) begin
            errors++;
            $display("FAIL collision_old_data: rvalid=%b data=%h required 1 %h", rvalid, rdata, oldv);
        end
        checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            errors++;
            $display("FAIL collision_commit: bvalid=%b bresp=%b required 1 00", bvalid, bresp);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) begin
                checks++;
                if (rvalid !== 1'b0 || bvalid !== 1'b1) begin
                    errors++;
                    $display("FAIL read_during_b: rvalid=%b bvalid=%b required 0 1", rvalid, bvalid);
                end
            end
            if (!(bvalid === 1'b1 && bresp === 2'b00 && awready === 1'b0 && wready === 1'b0))
                unstable = 1'b1;
        end
        checks++;
        if (unstable !== 1'b0) begin
            errors++;
            $display("FAIL b_backpressure_stable: unstable=%b required 0", unstable);
        end
        bready = 1'b1;
        tick();
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
            errors++;
            $display("FAIL b_release: bvalid=%b awready=%b wready=%b required 0 1 1", bvalid, awready, wready);
        end
        model[16] = newv;
        do_read(32'h40, d, r, lat);
        checks++;
        if (d !== newv) begin
            errors++;
            $display("FAIL collision_new_data: data=%h required %h", d, newv);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] v, d;
        logic [1:0] r;
        int lat;
        logic [40:0] outs;
        v = model[20];
        awvalid = 1'b1; awaddr = 32'h50;
        tick();
        awvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        outs = {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp};
        checks++;
        if (outs !== 41'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h required 0", outs);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({awready, wready, arready, bvalid} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_release_ready: got %b required 1110", {awready, wready, arready, bvalid});
        end
        wvalid = 1'b1; wdata = ~v; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        tick();
        tick();
        checks++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            errors++;
            $display("FAIL stale_aw_dropped: bvalid=%b awready=%b required 0 1", bvalid, awready);
        end
        awvalid = 1'b1; awaddr = 32'h54;
        tick();
        awvalid = 1'b0;
        tick();
        model[21] = ~v;
        do_read(32'h50, d, r, lat);
        checks++;
        if (d !== v) begin
            errors++;
            $display("FAIL reset_ram_unchanged: data=%h required %h", d, v);
        end
        do_read(32'h54, d, r, lat);
        checks++;
        if (d !== ~v) begin
            errors++;
            $display("FAIL post_reset_write: data=%h required %h", d, ~v);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, d, got, exp_d;
        logic [3:0]  s;
        logic [1:0]  r, er;
        int lat, k;
        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k < 7)       a = 32'($urandom_range(0, DEPTH - 1) * 4);
            else if (k == 7) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
            else             a = ($urandom & 32'hFFFF_FFFC) | 32'h200;
            er = exp_resp(a);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
                checks++;
                if (r !== er || lat != 0) begin
                    errors++;
                    $display("FAIL rand_write: addr=%h bresp=%b lat=%0d required %b lat 0", a, r, lat, er);
                end
            end else begin
                exp_d = (er == 2'b00) ? model[int'(a / 4)] : 32'd0;
                do_read(a, got, r, lat);
                checks++;
                if (got !== exp_d || r !== er || lat != 0) begin
                    errors++;
                    $display("FAIL rand_read: addr=%h data=%h rresp=%b lat=%0d required %h %b lat 0",
                             a, got, r, lat, exp_d, er);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_aligned_rw();
        test_channel_order();
        test_strobe();
        test_errors();
        test_backpressure_collision();
        test_reset_mid_write();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_mem_slave.md
Name: axil_mem_slave

Overview:
- Parametrised AXI4-Lite slave backed by an internal word-addressed RAM of DEPTH x DATA_W.
- Next generation of the team's single-FSM AXI-Lite slave. Adds:
  - independent, concurrently running read and write engines;
  - AW and W accepted in either order, or in the same cycle;
  - byte strobes;
  - alignment and range checking;
  - single-cycle read latency.
- Sits behind the interconnect as a scratchpad or register memory for the AXI-Lite master blocks.

Parameters:
- ADDR_W, 32: AXI address width in bits.
- DATA_W, 32: data width; legal values are 32 or 64.
- DEPTH, 128: number of words; must be a power of 2, at least 2.

Ports:
- s_axi_aclk  in  1  clock; all logic on rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- s_axi_awvalid  in  1  write-address valid.
- s_axi_awready  out  1  write-address ready.
- s_axi_awaddr  in  ADDR_W  byte write address.
- s_axi_wvalid  in  1  write-data valid.
- s_axi_wready  out  1  write-data ready.
- s_axi_wdata  in  DATA_W  write data.
- s_axi_wstrb  in  DATA_W/8  byte enables.
- s_axi_bvalid  out  1  write-response valid.
- s_axi_bready  in  1  write-response ready.
- s_axi_bresp  out  2  write response.
- s_axi_arvalid  in  1  read-address valid.
- s_axi_arready  out  1  read-address ready.
- s_axi_araddr  in  ADDR_W  byte read address.
- s_axi_rvalid  out  1  read-data valid.
- s_axi_rready  in  1  read-data ready.
- s_axi_rdata  out  DATA_W  read data.
- s_axi_rresp  out  2  read response.

Behaviour:
- Reset: asynchronous, active-low. While reset is asserted, every output is 0 and both FSMs go to IDLE. RAM contents are not reset.
- The first cycle after deassertion drives awready = wready = arready = 1 (all outputs registered).
- Address decode:
  - LSB = log2(DATA_W/8); word index = addr[LSB+log2(DEPTH)-1 : LSB].
  - OKAY (2'b00): aligned (addr[LSB-1:0] == 0) and addr < DEPTH*(DATA_W/8).
  - SLVERR (2'b10): misaligned.
  - DECERR (2'b11): out of range. Misalignment takes priority over range.
  - Error accesses never modify the RAM.
- Write FSM states:
  - W_IDLE: awready and wready are each high until their own handshake.
    - AW and W are captured independently into holding regs.
    - An already-held channel drops its ready and ignores further valids.
    - On the edge where both are held (captured earlier or this edge): commit, then go to W_RESP.
    - Commit means the RAM bytes with wstrb[i]=1 update, and bvalid=1 with bresp from decode.
    - AW and W handshaking in the same cycle gives bvalid on the next cycle.
    - wstrb == 0 on a valid address gives OKAY with no RAM change.
  - W_RESP: awready = wready = 0; bvalid and bresp are held stable until bready.
    - On the bvalid & bready edge: bvalid=0, bresp=0, both readies return to 1, go to W_IDLE.
    - Sustained best throughput is one write per 2 cycles.
- Read FSM states:
  - R_IDLE: arready=1.
    - On AR handshake: arready=0, rdata = RAM[index] (0 on error), rresp from decode, rvalid=1 next cycle, go to R_DATA.
  - R_DATA: rvalid, rdata and rresp are held stable until rready.
    - On the handshake edge: rvalid=0, rdata=0, rresp=0, arready=1, go to R_IDLE.
- Read latency: AR handshake to rvalid is exactly 1 cycle.
- Concurrency: read and write engines never block each other.
- Same-word collision: an AR handshake on the same edge as a write commit returns the OLD data (read-before-write). Any later read returns the new data.
- Reset mid-transaction: outputs clear asynchronously and the in-flight transaction is dropped. A write committed before reset stays in RAM; a half-captured AW or W is discarded.
- Valid-without-ready: inputs are sampled only on handshake. The slave never depends on the master keeping valid high after the handshake.

Optional Feature:
- Macro: AXIL_MEM_ERR_CNT_EN.
- Defined:
  - Adds output port err_cnt, out, 16 bits, reset to 0.
  - Increments by 1 on every B or R handshake whose resp != OKAY.
  - A simultaneous B-error and R-error adds 2.
  - Saturates at 16'hFFFF.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Aligned write, then read back. Stimulus: AW and W in the same cycle, awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, bready=1.
  - Response: bvalid 1 cycle later with bresp=00.
  - Read of 0x10: rvalid exactly 1 cycle after the AR handshake, rdata=0xDEADBEEF, rresp=00.
- Channel ordering: W at cycle 0 and AW at cycle 3 (addr 0x20, data 0x11223344); then W-after-AW at addr 0x24.
  - Response: bvalid only after both handshakes; readback 0x11223344 and the second word both correct.
- Byte strobes: on 0x30 holding 0xAABBCCDD, write 0x00000055 with wstrb=4'b0001.
  - Response: readback 0xAABBCC55.
- Errors (defaults): write to 0x200, write to 0x13, read of 0x1FC.
  - Response: 0x200 gives bresp=11; 0x13 gives bresp=10; 0x1FC reads with rresp=00.
  - No RAM change; with AXIL_MEM_ERR_CNT_EN, err_cnt=2.
- Backpressure plus collision: hold bready=0 for 5 cycles, then a read of the same word on the commit edge.
  - Response: bvalid/bresp stable and awready=wready=0 throughout; the read returns the old value.
  - The read completes while B is still pending.
- Async reset mid-write: assert aresetn=0 between the AW and W handshakes.
  - Response: all outputs 0 immediately.
  - After release: readies are 1, no stale bvalid, and the RAM at the target address is unchanged.
